stall_flush_unit: RTL and testbench
===================================

# stall_flush_unit

Pipeline control block for the 5-stage RISC-V core. It generates the stall and flush enables that the pipeline registers consume, covering the hazards operand forwarding cannot resolve:
- load-use dependencies;
- taken branches and jumps;
- multi-cycle data-memory accesses, through a valid/ready handshake.

It also keeps saturating stall/flush performance counters and a sticky memory-timeout flag.

## Interface
Parameters:
- CNT_W, 16, width of each performance counter
- TIMEOUT, 255, maximum cycles allowed in WAIT before the timeout is flagged (1..65535)

Ports:
- clk  in  1  core clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset
- rs1D  in  5  source register 1 of the instruction in Decode
- rs2D  in  5  source register 2 of the instruction in Decode
- rdE  in  5  destination register of the instruction in Execute
- memreadE  in  1  instruction in Execute is a load
- pcsrcE  in  1  taken branch or jump resolved in Execute
- memopM  in  1  instruction in Memory is a load or store
- dmem_ready  in  1  data memory accepts/completes the request this cycle
- dmem_valid  out  1  request valid toward data memory
- stallF, stallD, stallE, stallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers
- flushD, flushE, flushW  out  1 each  clear IF/ID, clear ID/EX, insert a bubble into MEM/WB
- mem_timeout  out  1  sticky flag: a WAIT episode reached TIMEOUT cycles
- stall_cnt  out  CNT_W  cycles with stallF high, saturating
- flush_cnt  out  CNT_W  cycles with flushD high, saturating

## Operation
- **Reset:** while rst=0:
  - all stall, flush and dmem_valid outputs are forced to 0 combinationally;
  - state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- **State machine:** two states, RUN and WAIT.
- **RUN**
  - dmem_valid = memopM.
  - memopM=1 and dmem_ready=0 (memory wait):
    - next state is WAIT;
    - this cycle stallF=stallD=stallE=stallM=1 and flushW=1;
    - flushD=flushE=0.
  - memopM=1 and dmem_ready=1: the access completes in the cycle. Stay in RUN with no stall.
- **WAIT**
  - dmem_valid=1; stallF/D/E/M=1; flushW=1; flushD=flushE=0.
  - On dmem_ready=1: return to RUN. That cycle all stalls and flushW are still asserted, so the access completes and M advances on the next edge.
- **Load-use:** lu = memreadE & (rdE≠0) & ((rdE==rs1D) | (rdE==rs2D)).
  - In RUN without a memory wait, lu=1 gives stallF=stallD=1 and flushE=1.
- **Branch:** in RUN without a memory wait, pcsrcE=1 gives flushD=1 and flushE=1.
  - The branch flush overrides the load-use stall: stallF=stallD=0.
- **Priority:**
  1. reset
  2. memory wait
  3. branch
  4. load-use
- A branch or load-use condition present during WAIT takes effect on the first RUN cycle after release, because E and D are frozen.
- **Wait counter:**
  - The 16-bit counter increments in WAIT and clears on entering RUN.
  - When it reaches TIMEOUT-1 in WAIT and dmem_ready=0, mem_timeout is set. It stays set until reset.
  - The FSM keeps waiting after the timeout. The flag is diagnostic only.
- **Counters:**
  - stall_cnt increments on every clock with stallF=1.
  - flush_cnt increments on every clock with flushD=1.
  - Both hold at 2^CNT_W−1.

## Timing
- All control outputs are combinational from the inputs and the registered state, with zero-cycle latency.
- A memory wait stalls for N+1 cycles, where N is the number of cycles before dmem_ready rises.
- A load-use hazard inserts exactly 1 bubble.
- A taken branch costs 2 cycles: 2 instructions are flushed.
- dmem_valid, once high, stays high until the cycle in which dmem_ready=1. It never drops mid-request except on reset.
- Reset mid-WAIT returns the FSM to RUN immediately and drops dmem_valid asynchronously.
- Counter and flag updates appear one cycle after the qualifying event.

## Test plan
- **Reset:** hold rst=0 with pcsrcE=1, memopM=1 -> all outputs 0, counters 0. Release -> flushD=flushE=1, dmem_valid=1.
- **Load-use:** memreadE=1, rdE=5, rs2D=5 for 1 cycle -> stallF=stallD=flushE=1 for exactly 1 cycle, stall_cnt=1. Repeat with rdE=0 -> no stall.
- **Branch:** pcsrcE=1 together with a load-use match -> flushD=flushE=1, stallF=stallD=0, flush_cnt increments by 1.
- **Memory wait:** memopM=1, dmem_ready low for 3 cycles then high -> 4 cycles of stallF/D/E/M=1, flushW=1, dmem_valid=1. State is WAIT for 3 cycles, then RUN. stall_cnt=4.
- **Overlap:** pcsrcE=1 arriving during WAIT -> flushD=0 throughout WAIT; flushD=flushE=1 on the first RUN cycle.
- **Timeout and saturation:** with TIMEOUT=4, hold dmem_ready=0 for 6 cycles -> mem_timeout rises after the 4th WAIT cycle and remains set after release. With CNT_W=3, 10 stall cycles -> stall_cnt=7.

Source files
------------

// File: rtl/stall_flush_unit.sv
// Pipeline stall/flush controller for the 5-stage core: resolves load-use, taken-branch
// and multi-cycle data-memory hazards, with saturating perf counters and a sticky timeout flag.
module stall_flush_unit #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rdE,
    input  logic             memreadE,
    input  logic             pcsrcE,
    input  logic             memopM,
    input  logic             dmem_ready,
    output logic             dmem_valid,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam logic [15:0]      WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0]      WAIT_MAX  = 16'hFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             lu_s;

    assign lu_s = memreadE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));

    // Next state and control outputs; memory wait outranks branch, branch outranks load-use
    always_comb begin
        state_d    = state_q;
        dmem_valid = 1'b0;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushW     = 1'b0;
        if (!rst) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    dmem_valid = memopM;
                    if (memopM && !dmem_ready) begin
                        state_d = ST_WAIT;
                        stallF  = 1'b1;
                        stallD  = 1'b1;
                        stallE  = 1'b1;
                        stallM  = 1'b1;
                        flushW  = 1'b1;
                    end else if (pcsrcE) begin
                        flushD = 1'b1;
                        flushE = 1'b1;
                    end else if (lu_s) begin
                        stallF = 1'b1;
                        stallD = 1'b1;
                        flushE = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_WAIT: begin
                    // Stalls stay up in the release cycle so M advances on the next edge
                    dmem_valid = 1'b1;
                    stallF     = 1'b1;
                    stallD     = 1'b1;
                    stallE     = 1'b1;
                    stallM     = 1'b1;
                    flushW     = 1'b1;
                    if (dmem_ready) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    // Wait-episode counter, sticky timeout flag and saturating perf counters
    always_comb begin
        wait_cnt_d    = 16'd0;
        mem_timeout_d = mem_timeout_q;
        stall_cnt_d   = stall_cnt_q;
        flush_cnt_d   = flush_cnt_q;
        if ((state_q == ST_WAIT) && (state_d == ST_WAIT) && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end else if ((state_q == ST_WAIT) && (state_d == ST_WAIT)) begin
            wait_cnt_d = wait_cnt_q;
        end else begin
            wait_cnt_d = 16'd0;
        end
        if ((state_q == ST_WAIT) && !dmem_ready && (wait_cnt_q == WAIT_LAST)) begin
            mem_timeout_d = 1'b1;
        end else begin
            mem_timeout_d = mem_timeout_q;
        end
        if (stallF && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flushD && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // State, wait counter, flag and perf counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            wait_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
            stall_cnt_q   <= {CNT_W{1'b0}};
            flush_cnt_q   <= {CNT_W{1'b0}};
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_stall_flush_unit.sv
// Bench for stall_flush_unit: directed scenarios plus randomized traffic against an
// episode-level reference model of the pipeline control rules.
module tb_stall_flush_unit;

    localparam int CW  = 3;
    localparam int TO  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1D, rs2D, rdE;
    logic          memreadE, pcsrcE, memopM, dmem_ready;
    logic          dmem_valid, stallF, stallD, stallE, stallM, flushD, flushE, flushW;
    logic          mem_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [7:0]    ctrl;

    int checks = 0;
    int passes = 0;

    // reference model state
    bit m_wait;
    int m_len;
    bit m_to;
    int m_sc;
    int m_fc;

    stall_flush_unit #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rdE(rdE),
        .memreadE(memreadE), .pcsrcE(pcsrcE), .memopM(memopM), .dmem_ready(dmem_ready),
        .dmem_valid(dmem_valid), .stallF(stallF), .stallD(stallD), .stallE(stallE),
        .stallM(stallM), .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    assign ctrl = {dmem_valid, stallF, stallD, stallE, stallM, flushD, flushE, flushW};

    // {valid, stallF, stallD, stallE, stallM, flushD, flushE, flushW}
    function automatic logic [7:0] model_ctrl();
        logic [7:0] r;
        logic       lu;
        r  = 8'h00;
        lu = memreadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));
        if (rst !== 1'b1) r = 8'h00;
        else if (m_wait || (memopM && !dmem_ready)) r = 8'b1111_1001;
        else begin
            r[7] = memopM;
            if (pcsrcE) begin
                r[2] = 1'b1;
                r[1] = 1'b1;
            end else if (lu) begin
                r[6] = 1'b1;
                r[5] = 1'b1;
                r[1] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_clear();
        m_wait = 1'b0; m_len = 0; m_to = 1'b0; m_sc = 0; m_fc = 0;
    endtask

    task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] d, input logic mr, input logic pc,
                         input logic mo, input logic rdy);
        @(negedge clk);
        rst = r; rs1D = a1; rs2D = a2; rdE = d;
        memreadE = mr; pcsrcE = pc; memopM = mo; dmem_ready = rdy;
        if (!r) model_clear();
        #1;
    endtask

    // advance one clock and update the model from the pre-edge inputs
    task automatic tick();
        logic [7:0] e;
        e = model_ctrl();
        @(posedge clk);
        if (rst) begin
            if (e[6] && m_sc < MAXC) m_sc++;
            if (e[2] && m_fc < MAXC) m_fc++;
            if (m_wait) begin
                if (dmem_ready) begin
                    m_wait = 1'b0;
                    m_len  = 0;
                end else begin
                    m_len++;
                    if (m_len >= TO) m_to = 1'b1;
                end
            end else if (memopM && !dmem_ready) begin
                m_wait = 1'b1;
                m_len  = 0;
            end
        end else begin
            model_clear();
        end
        #1;
    endtask

    task automatic reset_dut();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (ctrl !== 8'h00) $display("FAIL reset_ctrl: got %b expected %b", ctrl, 8'h00);
        else passes++;
        tick();
        checks++;
        if ({mem_timeout, stall_cnt, flush_cnt} !== 7'd0)
            $display("FAIL reset_regs: got %b expected 0", {mem_timeout, stall_cnt, flush_cnt});
        else passes++;
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (ctrl !== 8'b1000_0110) $display("FAIL reset_release: got %b expected %b", ctrl, 8'b1000_0110);
        else passes++;
        tick();
        checks++;
        if (flush_cnt !== 3'd1) $display("FAIL reset_flush_cnt: got %0d expected 1", flush_cnt);
        else passes++;
    endtask

    task automatic test_load_use();
        reset_dut();
        drive(1'b1, 5'd1, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== 8'b0110_0010) $display("FAIL lu_stall: got %b expected %b", ctrl, 8'b0110_0010);
        else passes++;
        tick();
        checks++;
        if (stall_cnt !== 3'd1) $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt);
        else passes++;
        drive(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== 8'h00) $display("FAIL lu_one_bubble: got %b expected 0", ctrl);
        else passes++;
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== 8'h00) $display("FAIL lu_rd_zero: got %b expected 0", ctrl);
        else passes++;
        tick();
        drive(1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== 8'b0110_0010) $display("FAIL lu_rs1: got %b expected %b", ctrl, 8'b0110_0010);
        else passes++;
        tick();
        checks++;
        if (stall_cnt !== 3'd2) $display("FAIL lu_stall_cnt2: got %0d expected 2", stall_cnt);
        else passes++;
    endtask

    task automatic test_branch();
        reset_dut();
        drive(1'b1, 5'd3, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ctrl !== 8'b0000_0110) $display("FAIL br_over_lu: got %b expected %b", ctrl, 8'b0000_0110);
        else passes++;
        tick();
        checks++;
        if ({stall_cnt, flush_cnt} !== {3'd0, 3'd1})
            $display("FAIL br_counts: got stall=%0d flush=%0d expected 0/1", stall_cnt, flush_cnt);
        else passes++;
    endtask

    task automatic test_mem_wait();
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, (i == 3) ? 1'b1 : 1'b0);
            checks++;
            if (ctrl !== 8'b1111_1001) $display("FAIL mw_cycle%0d: got %b expected %b", i, ctrl, 8'b1111_1001);
            else passes++;
            tick();
        end
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ctrl !== 8'h00) $display("FAIL mw_back_to_run: got %b expected 0", ctrl);
        else passes++;
        checks++;
        if ({mem_timeout, stall_cnt} !== {1'b0, 3'd4})
            $display("FAIL mw_counts: got to=%b stall=%0d expected 0/4", mem_timeout, stall_cnt);
        else passes++;
        tick();
    endtask

    task automatic test_overlap();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, (i == 2) ? 1'b1 : 1'b0);
            checks++;
            if (ctrl !== 8'b1111_1001) $display("FAIL ov_wait%0d: got %b expected %b", i, ctrl, 8'b1111_1001);
            else passes++;
            tick();
        end
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        checks++;
        if (ctrl !== 8'b0000_0110) $display("FAIL ov_first_run: got %b expected %b", ctrl, 8'b0000_0110);
        else passes++;
        tick();
        checks++;
        if (flush_cnt !== 3'd1) $display("FAIL ov_flush_cnt: got %0d expected 1", flush_cnt);
        else passes++;
    endtask

    task automatic test_timeout_sat();
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            checks++;
            if (mem_timeout !== (i >= 4)) $display("FAIL to_edge%0d: got %b expected %b", i, mem_timeout, (i >= 4));
            else passes++;
        end
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++;
        if ({mem_timeout, stall_cnt} !== {1'b1, 3'd7})
            $display("FAIL to_sticky: got to=%b stall=%0d expected 1/7", mem_timeout, stall_cnt);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
            tick();
        end
        checks++;
        if (stall_cnt !== 3'd7) $display("FAIL sat_stall_cnt: got %0d expected 7", stall_cnt);
        else passes++;
    endtask

    task automatic test_random();
        logic [7:0] e;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0,
                  1'($urandom_range(0, 1)));
            e = model_ctrl();
            checks++;
            if (ctrl !== e) $display("FAIL rnd_ctrl@%0d: got %b expected %b", i, ctrl, e);
            else passes++;
            tick();
            checks++;
            if ({mem_timeout, stall_cnt, flush_cnt} !== {m_to, CW'(m_sc), CW'(m_fc)})
                $display("FAIL rnd_regs@%0d: got to=%b s=%0d f=%0d expected to=%b s=%0d f=%0d",
                         i, mem_timeout, stall_cnt, flush_cnt, m_to, m_sc, m_fc);
            else passes++;
        end
    endtask

    initial begin
        rst = 1'b0; rs1D = 5'd0; rs2D = 5'd0; rdE = 5'd0;
        memreadE = 1'b0; pcsrcE = 1'b0; memopM = 1'b0; dmem_ready = 1'b0;
        model_clear();
        test_reset();
        test_load_use();
        test_branch();
        test_mem_wait();
        test_overlap();
        test_timeout_sat();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
